// File: rtl/risc_ctrl_if.sv
// Control-sequencer bus between the program store, the
// register-file/ALU datapath and risc_ctrl_fsm.
interface risc_ctrl_if;
  logic       run;
  logic [7:0] instr;
  logic       zero;
  logic       mem_ack;
  logic [2:0] pc;
  logic [7:0] ir;
  logic       rf_we;
  logic [1:0] rd_sel;
  logic [1:0] rs_sel;
  logic [1:0] alu_op;
  logic [2:0] imm;
  logic       mem_req;
  logic       mem_we;
  logic       busy;
  logic       halted;

  modport master (
    input  run, instr, zero, mem_ack,
    output pc, ir, rf_we, rd_sel, rs_sel,
    output alu_op, imm, mem_req, mem_we,
    output busy, halted
  );

  modport slave (
    output run, instr, zero, mem_ack,
    input  pc, ir, rf_we, rd_sel, rs_sel,
    input  alu_op, imm, mem_req, mem_we,
    input  busy, halted
  );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE(/MEMORY) sequencer
// for the 8-instruction RISC core; owns pc and ir.
module risc_ctrl_fsm (
  input logic         clk,
  input logic         rst,
  risc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, HALT
  } state_t;

  state_t     state;
  logic [2:0] pc;
  logic [7:0] ir;
  logic [2:0] op;
  logic       is_add, is_sub, is_ldi;
  logic       is_ld, is_st;
  logic       rf_we, mem_req, mem_we;
  logic [1:0] alu_op;

  assign op     = ir[7:5];
  assign is_add = (op == 3'b001);
  assign is_sub = (op == 3'b010);
  assign is_ldi = (op == 3'b011);
  assign is_ld  = (op == 3'b100);
  assign is_st  = (op == 3'b101);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        IDLE:   if (bus.run) state <= FETCH;
        FETCH: begin
          ir    <= bus.instr;
          state <= DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          state <= FETCH;
          unique case (op)
            3'b100, 3'b101: state <= MEMORY;
            3'b110: pc <= bus.zero ? ir[2:0] : pc + 3'd1;
            3'b111: begin
              if (ir[4]) state <= HALT;
              else       pc    <= ir[2:0];
            end
            default: pc <= pc + 3'd1;
          endcase
        end
        MEMORY: begin
          if (bus.mem_ack) begin
            pc    <= pc + 3'd1;
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // strobes come from state and ir; only the LD
  // write-back in MEMORY looks at mem_ack
  always_comb begin
    rf_we   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    alu_op  = 2'b00;
    unique case (state)
      EXECUTE: begin
        unique case (1'b1)
          is_add: begin
            rf_we  = 1'b1;
            alu_op = 2'b01;
          end
          is_sub: begin
            rf_we  = 1'b1;
            alu_op = 2'b10;
          end
          is_ldi: begin
            rf_we  = 1'b1;
            alu_op = 2'b00;
          end
          default: ;
        endcase
      end
      MEMORY: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        alu_op  = 2'b11;
        rf_we   = is_ld & bus.mem_ack;
      end
      default: ;
    endcase
  end

  assign bus.pc      = pc;
  assign bus.ir      = ir;
  assign bus.rd_sel  = ir[4:3];
  assign bus.rs_sel  = ir[2:1];
  assign bus.imm     = ir[2:0];
  assign bus.rf_we   = rf_we;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.alu_op  = alu_op;
  assign bus.busy    = (state != IDLE) && (state != HALT);
  assign bus.halted  = (state == HALT);
endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Scoreboard bench for risc_ctrl_fsm: strobe cycles are
// queued by the stimulus and checked by a negedge monitor.
module tb_risc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ff = 1'b1;
  logic mon_en = 1'b0;
  logic [7:0] prog [8];
  logic [14:0] q [$];
  int checks = 0;
  int errors = 0;

  risc_ctrl_if bus ();

  risc_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.instr = force_ff ? 8'hFF : prog[bus.pc];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  // {rf_we,mem_req,mem_we,alu_op,rd_sel,rs_sel,imm,pc}
  always @(negedge clk) begin
    logic [14:0] act;
    logic [14:0] e;
    act = {bus.rf_we, bus.mem_req, bus.mem_we, bus.alu_op,
           bus.rd_sel, bus.rs_sel, bus.imm, bus.pc};
    if (mon_en && (bus.rf_we || bus.mem_req)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h want none", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_strobe got %h want %h", act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    prog[0] = 8'h65;
    prog[1] = 8'h2A;
    prog[2] = 8'h8A;
    prog[3] = 8'hC5;
    prog[4] = 8'h00;
    prog[5] = 8'hC7;
    prog[6] = 8'hE7;
    prog[7] = 8'h00;
    bus.run = 1'b1;
    bus.zero = 1'b0;
    bus.mem_ack = 1'b0;

    // reset held with run=1 and instr=0xFF
    step(2);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_ir", int'(bus.ir), 0);
    chk("rst_rf_we", int'(bus.rf_we), 0);
    chk("rst_mem_req", int'(bus.mem_req), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_halted", int'(bus.halted), 0);

    // LDI r0,5 then ADD r1,r1
    q.push_back({1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 2'd2, 3'd5, 3'd0});
    q.push_back({1'b1, 1'b0, 1'b0, 2'b01, 2'd1, 2'd1, 3'd2, 3'd1});
    rst = 1'b0;
    force_ff = 1'b0;
    mon_en = 1'b1;
    step(1);
    chk("busy_after_run", int'(bus.busy), 1);
    bus.run = 1'b0;
    step(6);
    chk("pc_after_add", int'(bus.pc), 2);

    // LD r1,[r1] with two wait cycles
    q.push_back({1'b0, 1'b1, 1'b0, 2'b11, 2'd1, 2'd1, 3'd2, 3'd2});
    q.push_back({1'b0, 1'b1, 1'b0, 2'b11, 2'd1, 2'd1, 3'd2, 3'd2});
    q.push_back({1'b1, 1'b1, 1'b0, 2'b11, 2'd1, 2'd1, 3'd2, 3'd2});
    step(3);
    chk("ld_mem_req", int'(bus.mem_req), 1);
    step(2);
    chk("ld_pc_hold", int'(bus.pc), 2);
    bus.mem_ack = 1'b1;
    step(1);
    bus.mem_ack = 1'b0;
    chk("ld_pc_inc", int'(bus.pc), 3);
    chk("ld_req_drop", int'(bus.mem_req), 0);

    // BZ taken, BZ not taken, JMP, NOP wrap
    bus.zero = 1'b1;
    step(3);
    chk("bz_taken", int'(bus.pc), 5);
    bus.zero = 1'b0;
    step(3);
    chk("bz_not_taken", int'(bus.pc), 6);
    step(3);
    chk("jmp", int'(bus.pc), 7);
    prog[0] = 8'hF0;
    step(3);
    chk("nop_wrap", int'(bus.pc), 0);

    // HALT is absorbing
    step(3);
    chk("halt_ir", int'(bus.ir), 8'hF0);
    for (int i = 0; i < 10; i++) begin
      bus.run = ~bus.run;
      bus.mem_ack = ~bus.mem_ack;
      step(1);
      chk("halt_pc", int'(bus.pc), 0);
      chk("halt_flag", int'(bus.halted), 1);
      chk("halt_busy", int'(bus.busy), 0);
    end
    bus.run = 1'b0;
    bus.mem_ack = 1'b0;

    // ST r1,[r0] interrupted by reset in MEMORY
    rst = 1'b1;
    step(1);
    chk("rst2_halted", int'(bus.halted), 0);
    rst = 1'b0;
    prog[0] = 8'hA8;
    q.push_back({1'b0, 1'b1, 1'b1, 2'b11, 2'd1, 2'd0, 3'd0, 3'd0});
    q.push_back({1'b0, 1'b1, 1'b1, 2'b11, 2'd1, 2'd0, 3'd0, 3'd0});
    bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    step(4);
    chk("st_mem_we", int'(bus.mem_we), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_mem_req", int'(bus.mem_req), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_pc", int'(bus.pc), 0);
    chk("mid_rst_ir", int'(bus.ir), 0);
    step(2);
    chk("idle_stays", int'(bus.busy), 0);
    chk("sb_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
